keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad, synchronizes and debounces the row returns, and encodes each accepted key press into the calculator key code. Each accepted press produces one `kbEN` strobe with a matching `pressedkey` value. It is the producer side of the keyboard interface consumed by `mainFSB`: digits 0-9, equal=10, AC=11, plus=12, minus=13, mult=14, div=15.

---
 rtl/keypad_scanner.sv | 199 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad, synchronizes and debounces the row
// returns and turns each accepted press into a one-cycle strobe carrying the
// calculator key code (0-9 digits, 10 equal, 11 AC, 12 plus, 13 minus,
// 14 mult, 15 div).
//
// Parameters
//   SCAN_DIV        : cycles each column is driven low (>= 4)
//   DEBOUNCE_CYCLES : consecutive stable cycles to accept a press/release (>= 2)
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset, clears all state
//   rows       : row returns, active-low, asynchronous to clk
//   cols       : column drive, active-low, one-hot-low, registered
//   kbEN       : one-cycle strobe, a new key was accepted
//   pressedkey : code of the last accepted key, updated with kbEN
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       kbEN,
    output logic [3:0] pressedkey
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    // Key code for a (row, column) position of the matrix.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = 4'd12;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = 4'd13;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = 4'd14;
            4'b11_00: code = 4'd11;
            4'b11_01: code = 4'd0;
            4'b11_10: code = 4'd10;
            default:  code = 4'd15;
        endcase
        return code;
    endfunction

    // Lowest-index row that is pulled low; lowest row wins within a column.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rv);
        logic [1:0] r;
        if (!rv[0])      r = 2'd0;
        else if (!rv[1]) r = 2'd1;
        else if (!rv[2]) r = 2'd2;
        else             r = 2'd3;
        return r;
    endfunction

    // Saturating increment: the debounce/release counter never wraps.
    function automatic logic [DB_W-1:0] db_inc(input logic [DB_W-1:0] v);
        return (v == DB_MAX) ? v : v + DB_W'(1);
    endfunction

    // Registers
    logic [3:0]        sync1_q, sync1_d;
    logic [3:0]        rs_q, rs_d;
    state_t            state_q, state_d;
    logic [1:0]        col_q, col_d;
    logic [3:0]        cols_q, cols_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [DB_W-1:0]   cnt_q, cnt_d;
    logic [1:0]        row_q, row_d;
    logic              kb_en_q, kb_en_d;
    logic [3:0]        key_q, key_d;

    // Next-state and output logic
    always_comb begin
        sync1_d    = rows;
        rs_d       = sync1_q;
        state_d    = state_q;
        col_d      = col_q;
        scan_cnt_d = scan_cnt_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        kb_en_d    = 1'b0;
        key_d      = key_q;

        case (state_q)
            SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    // Sample point: the synchronizer has settled on this column.
                    if (rs_q != 4'hF) begin
                        row_d   = lowest_low_row(rs_q);
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d      = col_q + 2'd1;
                        scan_cnt_d = '0;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end

            DEBOUNCE: begin
                if (rs_q[row_q]) begin
                    // Bounce: abandon this key and continue the scan.
                    state_d    = SCAN;
                    col_d      = col_q + 2'd1;
                    scan_cnt_d = '0;
                end else if (cnt_q >= DB_LAST) begin
                    // This low cycle brings the count to DEBOUNCE_CYCLES.
                    kb_en_d = 1'b1;
                    key_d   = key_code(row_q, col_q);
                    cnt_d   = '0;   // counter is reused for the release count
                    state_d = WAIT_RELEASE;
                end else begin
                    cnt_d = db_inc(cnt_q);
                end
            end

            WAIT_RELEASE: begin
                if (rs_q == 4'hF) begin
                    if (cnt_q >= DB_LAST) begin
                        state_d    = SCAN;
                        col_d      = col_q + 2'd1;
                        scan_cnt_d = '0;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = db_inc(cnt_q);
                    end
                end else begin
                    // Any key still down on the frozen column restarts release.
                    cnt_d = '0;
                end
            end

            default: begin
                state_d    = SCAN;
                scan_cnt_d = '0;
                cnt_d      = '0;
            end
        endcase

        cols_d = ~(4'b0001 << col_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 4'hF;
            rs_q       <= 4'hF;
            state_q    <= SCAN;
            col_q      <= 2'd0;
            cols_q     <= 4'b1110;
            scan_cnt_q <= '0;
            cnt_q      <= '0;
            row_q      <= 2'd0;
            kb_en_q    <= 1'b0;
            key_q      <= 4'd0;
        end else begin
            sync1_q    <= sync1_d;
            rs_q       <= rs_d;
            state_q    <= state_d;
            col_q      <= col_d;
            cols_q     <= cols_d;
            scan_cnt_q <= scan_cnt_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            kb_en_q    <= kb_en_d;
            key_q      <= key_d;
        end
    end

    assign cols       = cols_q;
    assign kbEN       = kb_en_q;
    assign pressedkey = key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8. A matrix model
// pulls rows[r] low while key (r,c) is held and column c is driven low.
// A monitor records every kbEN strobe and checks strobe width and that
// pressedkey only moves with kbEN.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DC = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        kbEN;
    logic [3:0]  pressedkey;
    logic [15:0] held = '0;

    int vectors = 0;
    int miscompares = 0;
    int strobes[$];

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk),
        .reset(reset),
        .rows(rows),
        .cols(cols),
        .kbEN(kbEN),
        .pressedkey(pressedkey)
    );

    // Keypad matrix
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    function automatic void chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference key map derived from the layout rules
    function automatic int ref_code(input int r, input int c);
        if (c == 3) return 12 + r;
        if (r == 3) return (c == 0) ? 11 : ((c == 1) ? 0 : 10);
        return 3 * r + c + 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        held  = '0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
    endtask

    task automatic wait_strobe(input int n0, input int bound, output int lat, output int code);
        lat = 0;
        while (strobes.size() == n0 && lat < bound) begin
            tick(1);
            lat++;
        end
        code = (strobes.size() > n0) ? strobes[n0] : -1;
    endtask

    task automatic wait_cols_not(input logic [3:0] v, input int bound, output int ok);
        int k = 0;
        while (cols == v && k < bound) begin
            tick(1);
            k++;
        end
        ok = (cols != v) ? 1 : 0;
    endtask

    task automatic wait_cols_is(input logic [3:0] v, input int bound, output int ok);
        int k = 0;
        while (cols != v && k < bound) begin
            tick(1);
            k++;
        end
        ok = (cols == v) ? 1 : 0;
    endtask

    // Strobe monitor
    logic       prev_en = 1'b0;
    logic [3:0] prev_key = 4'd0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_en  = 1'b0;
                prev_key = pressedkey;
            end else begin
                if (kbEN) begin
                    chk("kben_one_cycle", int'(prev_en), 0);
                    strobes.push_back(int'(pressedkey));
                end else begin
                    chk("pressedkey_hold", int'(pressedkey), int'(prev_key));
                end
                prev_en  = kbEN;
                prev_key = pressedkey;
            end
        end
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  exp_cols;
        logic        exp_kben;
    } idle_vec_t;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] exp_code;
    } key_vec_t;

    idle_vec_t idle_tab[16];
    key_vec_t  calc_tab[4];

    initial begin
        int lat, code, ok, n0, r, c;

        for (int i = 0; i < 16; i++) begin
            idle_tab[i].keys     = '0;
            idle_tab[i].exp_cols = ~(4'b0001 << (i / 4));
            idle_tab[i].exp_kben = 1'b0;
        end
        calc_tab[0] = '{r: 0, c: 0, exp_code: 4'd1};
        calc_tab[1] = '{r: 0, c: 3, exp_code: 4'd12};
        calc_tab[2] = '{r: 0, c: 0, exp_code: 4'd1};
        calc_tab[3] = '{r: 3, c: 2, exp_code: 4'd10};

        // Idle after reset
        do_reset();
        chk("reset_cols", int'(cols), 4'b1110);
        chk("reset_kben", int'(kbEN), 0);
        chk("reset_key", int'(pressedkey), 0);
        for (int i = 0; i < 32; i++) begin
            held = idle_tab[i % 16].keys;
            chk("idle_cols", int'(cols), int'(idle_tab[i % 16].exp_cols));
            chk("idle_kben", int'(kbEN), int'(idle_tab[i % 16].exp_kben));
            tick(1);
        end
        chk("idle_no_strobe", strobes.size(), 0);
        chk("idle_key", int'(pressedkey), 0);

        // Single press of key (0,0)
        do_reset();
        n0 = strobes.size();
        held[0] = 1'b1;
        wait_strobe(n0, 15, lat, code);
        chk("single_code", code, ref_code(0, 0));
        chk("single_latency_ok", (lat <= 2 + SD + DC + 1) ? 1 : 0, 1);
        tick(200 - lat);
        chk("single_no_repeat", strobes.size(), n0 + 1);
        chk("single_cols_frozen", int'(cols), 4'b1110);
        held = '0;
        for (int i = 0; i < DC; i++) begin
            tick(1);
            chk("release_cols_frozen", int'(cols), 4'b1110);
        end
        wait_cols_not(4'b1110, 6, ok);
        chk("release_resume_scan", int'(cols), 4'b1101);

        // Calculator sequence
        n0 = strobes.size();
        for (int i = 0; i < 4; i++) begin
            held[calc_tab[i].r * 4 + calc_tab[i].c] = 1'b1;
            wait_strobe(n0 + i, 40, lat, code);
            chk("calc_code", code, int'(calc_tab[i].exp_code));
            chk("calc_ref", code, ref_code(calc_tab[i].r, calc_tab[i].c));
            tick(10);
            held = '0;
            tick(20);
        end
        chk("calc_count", strobes.size(), n0 + 4);

        // Bounce rejection on key (1,1)
        n0 = strobes.size();
        for (int i = 0; i < 20; i++) begin
            held[5] = ~held[5];
            tick(3);
        end
        chk("bounce_no_strobe", strobes.size(), n0);
        held[5] = 1'b1;
        wait_strobe(n0, 40, lat, code);
        chk("bounce_code", code, 5);
        tick(5);
        for (int i = 0; i < 6; i++) begin
            held[5] = 1'b0;
            tick(5);
            chk("bounce_release_frozen", int'(cols), 4'b1101);
            held[5] = 1'b1;
            tick(3);
        end
        chk("bounce_single_strobe", strobes.size(), n0 + 1);
        held = '0;
        wait_cols_not(4'b1101, 15, ok);
        chk("bounce_release_resume", int'(cols), 4'b1011);

        // Simultaneous keys 5 and 9
        do_reset();
        n0 = strobes.size();
        held[5]  = 1'b1;
        held[10] = 1'b1;
        wait_strobe(n0, 40, lat, code);
        chk("simul_first", code, 5);
        tick(20);
        chk("simul_only_one", strobes.size(), n0 + 1);
        held[5] = 1'b0;
        wait_strobe(n0 + 1, 40, lat, code);
        chk("simul_second", code, 9);
        tick(10);
        held = '0;
        tick(20);
        chk("simul_count", strobes.size(), n0 + 2);

        // Reset during debounce of key 7 (2,0)
        wait_cols_not(4'b1110, 40, ok);
        wait_cols_is(4'b1110, 40, ok);
        chk("rst_align_col0", ok, 1);
        n0 = strobes.size();
        held[8] = 1'b1;
        tick(SD + 4);
        chk("rst_pre_no_strobe", strobes.size(), n0);
        chk("rst_pre_key", int'(pressedkey), 9);
        reset = 1'b1;
        #1;
        chk("rst_kben", int'(kbEN), 0);
        chk("rst_key", int'(pressedkey), 0);
        chk("rst_cols", int'(cols), 4'b1110);
        tick(3);
        reset = 1'b0;
        chk("rst_aborted_no_strobe", strobes.size(), n0);
        wait_strobe(n0, 20, lat, code);
        chk("rst_redebounce_code", code, 7);
        tick(30);
        chk("rst_once", strobes.size(), n0 + 1);
        held = '0;
        tick(20);

        // Randomized single presses against the reference map
        for (int i = 0; i < 12; i++) begin
            r  = int'($urandom_range(3, 0));
            c  = int'($urandom_range(3, 0));
            n0 = strobes.size();
            held[r*4+c] = 1'b1;
            wait_strobe(n0, 45, lat, code);
            chk("rand_code", code, ref_code(r, c));
            tick(int'($urandom_range(60, 5)));
            chk("rand_no_repeat", strobes.size(), n0 + 1);
            held = '0;
            tick(int'($urandom_range(40, 14)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
